// File: rtl/ysyx_22050133_dmem_responder.sv
// ----------------------------------------------------------------------------
// ysyx_22050133_dmem_responder
//
// Memory-side responder for the NPC MEM-stage data port. One read or write
// transaction is accepted on the request channel, held for a programmable
// number of wait cycles, performed against an internal word-organised SRAM
// array, and returned on the response channel. Byte-lane alignment happens
// here: write data/mask are shifted into the addressed 8-byte word, read data
// is shifted down and zero-filled.
//
// Parameters
//   DEPTH_WORDS  number of 64-bit words in the array (power of 2)
//   BASE_ADDR    byte address of word 0 (8-byte aligned)
//   LATENCY      wait cycles between acceptance and rsp_valid (0..15);
//                rsp_valid rises LATENCY+1 cycles after the accept edge
//
// Ports
//   clk        in   1   sole clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_wen    in   1   1 = write, 0 = read
//   req_addr   in   64  byte address
//   req_wdata  in   64  write data, LSB-aligned
//   req_wmask  in   8   byte enables, LSB-aligned (ignored for reads)
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts response
//   rsp_rdata  out  64  read data shifted down by the byte offset, zero-filled;
//                       0 for writes and errors
//   rsp_err    out  1   address out of range, or write crosses 8-byte boundary
// ----------------------------------------------------------------------------
module ysyx_22050133_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [60:0] DEPTH_LIM = 61'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Latched request
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;

  // FSM strobes
  logic        accept;
  logic        do_access;

  // --------------------------------------------------------------------------
  // Address decode on the latched request
  // --------------------------------------------------------------------------
  logic [2:0]    off;
  logic [60:0]   word_off;
  logic          below_base;
  logic          beyond_top;
  logic [15:0]   mask_sh;
  logic          cross_err;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [7:0]    lanes;
  logic [63:0]   wdata_sh;
  logic [63:0]   rd_word;
  logic [63:0]   rd_shift;
  logic          mem_we;

  logic [63:0] mem [DEPTH_WORDS];

  assign off        = addr_q[2:0];
  // BASE_ADDR is word aligned, so the word offset can be formed from the
  // upper address bits alone without a borrow from the byte offset.
  assign word_off   = addr_q[63:3] - BASE_ADDR[63:3];
  assign below_base = (addr_q < BASE_ADDR);
  assign beyond_top = (word_off >= DEPTH_LIM);

  // Mask shifted into a 16-lane window: anything landing in the upper half
  // belongs to the next word, which a single write may not touch.
  assign mask_sh    = {8'h00, wmask_q} << off;
  assign cross_err  = wen_q && (|mask_sh[15:8]);
  assign acc_err    = below_base || beyond_top || cross_err;

  assign idx        = word_off[AW-1:0];
  assign lanes      = mask_sh[7:0];
  assign wdata_sh   = wdata_q << {off, 3'b000};
  assign rd_word    = mem[idx];
  assign rd_shift   = rd_word >> {off, 3'b000};

  // Reset holds the FSM in IDLE, so do_access (and with it the array write)
  // is suppressed for any transaction that was in flight when reset hit.
  assign mem_we     = do_access && wen_q && !acc_err;

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing every word would turn the
  // SRAM into flops, and software never relies on power-up contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (lanes[b]) begin
          mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output logic
  // --------------------------------------------------------------------------
  // The counter is loaded with LATENCY on acceptance and counted down to zero
  // in WAIT; the edge that sees zero performs the access and raises
  // rsp_valid, giving LATENCY+1 cycles from acceptance to response.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    accept      = 1'b0;
    do_access   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          accept      = 1'b1;
          req_ready_d = 1'b0;
          cnt_d       = LAT_INIT;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || wen_q) ? 64'd0 : rd_shift;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        // rsp_valid is always high in RESP, so rsp_ready alone completes the
        // handshake; the response stays frozen until it does.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22050133_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050133_dmem_responder
//
// Directed bench for the data-memory responder (default parameters:
// 1024 words at 0x80000000, LATENCY=2). A table of transactions with
// hand-computed responses is applied in order, followed by hand-written
// sequences for reset, response backpressure and reset during WAIT.
// ----------------------------------------------------------------------------
module tb_ysyx_22050133_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  ysyx_22050133_dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int EXP_LAT = 3;  // LATENCY + 1

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Present a request (called #1 after a rising edge) and return #1 after
  // the edge that accepted it.
  task automatic send_req(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask);
    int k = 0;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
    end else begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_after_hs"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [63:0] held;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    req_wmask = 8'd0;
    rsp_ready = 1'b0;

    // ---------------------------------------------------------------- table
    //        wen   addr                   wdata                  mask   rdata                  err
    add_vec(1'b1, 64'h0000_0000_8000_0008, 64'h1122334455667788, 8'hFF, 64'h0,                1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_0008, 64'h0,                8'h00, 64'h1122334455667788, 1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_0010, 64'h0,                8'hFF, 64'h0,                1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_0013, 64'h000000000000ABCD, 8'h03, 64'h0,                1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_0010, 64'h0,                8'h00, 64'h000000ABCD000000, 1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_0013, 64'h0,                8'h00, 64'h000000000000ABCD, 1'b0);
    add_vec(1'b0, 64'h0000_0000_7FFF_FFF8, 64'h0,                8'h00, 64'h0,                1'b1);
    add_vec(1'b1, 64'h0000_0000_8000_0000, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0,                1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_0006, 64'h00000000FFFFFFFF, 8'h0F, 64'h0,                1'b1);
    add_vec(1'b0, 64'h0000_0000_8000_0000, 64'h0,                8'h00, 64'hDEADBEEFCAFEF00D, 1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_1FF8, 64'h0123456789ABCDEF, 8'hFF, 64'h0,                1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_1FF8, 64'h0,                8'h00, 64'h0123456789ABCDEF, 1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_1FFF, 64'h0,                8'hFF, 64'h0000000000000001, 1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_2000, 64'h0,                8'h00, 64'h0,                1'b1);
    add_vec(1'b1, 64'h0000_0000_0000_0010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0,                1'b1);
    add_vec(1'b1, 64'h0000_0000_8000_0008, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0,                1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_0008, 64'h0,                8'h00, 64'h1122334455667788, 1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_0007, 64'h000000000000005A, 8'h01, 64'h0,                1'b0);
    add_vec(1'b1, 64'h0000_0000_8000_0007, 64'h000000000000FFFF, 8'h03, 64'h0,                1'b1);
    add_vec(1'b0, 64'h0000_0000_8000_0000, 64'h0,                8'h00, 64'h5AADBEEFCAFEF00D, 1'b0);
    add_vec(1'b0, 64'h0000_0000_8000_0004, 64'h0,                8'h00, 64'h000000005AADBEEF, 1'b0);

    // ---------------------------------------------------------------- reset
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err",   64'(rsp_err), 64'd0);
    rst = 1'b1;
    check("release_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("first_edge_req_ready", 64'(req_ready), 64'd1);
    check("first_edge_rsp_valid", 64'(rsp_valid), 64'd0);

    // ------------------------------------------------------- table-driven run
    for (int i = 0; i < vecs.size(); i++) begin
      send_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      wait_rsp(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(EXP_LAT));
      check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 64'(rsp_err), 64'(vecs[i].exp_err));
      finish_rsp($sformatf("vec%0d", i));
    end

    // ---------------------------------------------------------- backpressure
    // A competing write is presented while the response is stalled; it must
    // be ignored because req_ready stays low.
    send_req(1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00);
    wait_rsp(lat);
    check("bp_latency", 64'(lat), 64'(EXP_LAT));
    held = rsp_rdata;
    check("bp_rdata", held, 64'h1122334455667788);
    req_wen   = 1'b1;
    req_addr  = 64'h0000_0000_8000_0008;
    req_wdata = 64'h0;
    req_wmask = 8'hFF;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d_rdata", c), rsp_rdata, 64'h1122334455667788);
      check($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    finish_rsp("bp");

    // rsp_ready held high through WAIT must not disturb timing or data.
    rsp_ready = 1'b1;
    send_req(1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00);
    wait_rsp(lat);
    check("bp_readback_latency", 64'(lat), 64'(EXP_LAT));
    check("bp_readback_rdata", rsp_rdata, 64'h1122334455667788);
    finish_rsp("bp_readback");

    // ---------------------------------------------------- reset during WAIT
    send_req(1'b1, 64'h0000_0000_8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_rdata", rsp_rdata, 64'd0);
    check("midrst_rsp_err",   64'(rsp_err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_req_ready", 64'(req_ready), 64'd1);
    send_req(1'b0, 64'h0000_0000_8000_0010, 64'h0, 8'h00);
    wait_rsp(lat);
    check("midrst_read_latency", 64'(lat), 64'(EXP_LAT));
    check("midrst_read_rdata", rsp_rdata, 64'h000000ABCD000000);
    check("midrst_read_err", 64'(rsp_err), 64'd0);
    finish_rsp("midrst_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound in case the DUT wedges somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
